// File: rtl/img_proc_pkg.sv
// Shared types, constants and helpers for the image capture datapath.
package img_proc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        FLUSH   = 2'd3
    } cap_state_t;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/pixel_lane_packer.sv
// Packs consecutive pixels into PIX_PER_WORD lanes of one memory word.
// A clear and a write in the same cycle start a fresh word: the written
// pixel lands in lane 0 and every other lane reads as zero.
module pixel_lane_packer #(
    parameter int PIX_W        = 16,
    parameter int PIX_PER_WORD = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [PIX_W-1:0]              data,
    input  logic                          clr,
    output logic [PIX_W*PIX_PER_WORD-1:0] word,
    output logic                          full
);

    localparam int IDX_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_PER_WORD - 1);

    logic [PIX_W-1:0] lanes [PIX_PER_WORD];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] base;

    // Lane written this cycle; a pending clear restarts at lane 0.
    always_comb begin
        base = clr ? '0 : idx;
        full = wr_en && (base == LAST_IDX);
    end

    // Lane storage and lane index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIX_PER_WORD; k++) lanes[k] <= '0;
            idx <= '0;
        end else begin
            if (clr) begin
                for (int k = 0; k < PIX_PER_WORD; k++) lanes[k] <= '0;
                idx <= '0;
            end
            if (wr_en) begin
                lanes[base] <= data;
                idx         <= (base == LAST_IDX) ? '0 : base + IDX_W'(1);
            end
        end
    end

    for (genvar k = 0; k < PIX_PER_WORD; k++) begin : g_flat
        assign word[k*PIX_W +: PIX_W] = lanes[k];
    end

endmodule

// File: rtl/img_capture_packer.sv
// Camera frame capture engine: arms on start, captures one frame of
// IMG_PIXELS pixels, writes packed words to the data memory, flags
// truncated frames and optionally re-arms after every frame.
module img_capture_packer import img_proc_pkg::*; #(
    parameter int PIX_W        = 16,
    parameter int PIX_PER_WORD = 16,
    parameter int IMG_PIXELS   = 784,
    parameter int ADDR_W       = 7
) (
    input  logic                          pxlclk,
    input  logic                          rst_n,
    input  logic                          iCCD_enable,
    input  logic                          iCCD_start,
    input  logic                          iCont,
    input  logic                          iFVAL,
    input  logic                          iDVAL,
    input  logic [PIX_W-1:0]              iDATA,
    output logic                          oDmem_wren,
    output logic [ADDR_W-1:0]             oDmem_addr,
    output logic [PIX_W*PIX_PER_WORD-1:0] oDmem_data,
    output logic [1:0]                    oState,
    output logic                          oBusy,
    output logic                          oCCD_done,
    output logic                          oFrame_err
);

    localparam int NUM_WORDS = ceil_div(IMG_PIXELS, PIX_PER_WORD);
    localparam int PC_W      = $clog2(IMG_PIXELS + 1);
    localparam logic [PC_W-1:0] LAST_PIX = PC_W'(IMG_PIXELS - 1);

    if ((2 ** ADDR_W) < NUM_WORDS) begin : g_addr_check
        $error("ADDR_W too narrow for NUM_WORDS");
    end

    logic             fval_r, fval_q, dval_r, start_r, start_q;
    logic [PIX_W-1:0] data_r;
    logic             fs, fe, start_pulse;

    cap_state_t       state, state_nx;
    logic [PC_W-1:0]  pix_cnt;
    logic [ADDR_W-1:0] word_cnt;
    logic             wren_r, done_r, err_r;
    logic [ADDR_W-1:0] addr_r;

    logic             cap_pix, last_pix, issue, trunc, lane_clr, lane_full;
    logic [PIX_W*PIX_PER_WORD-1:0] lane_word;

    // Input stage: FVAL/DVAL/DATA share one register so they stay aligned.
    always_ff @(posedge pxlclk or negedge rst_n) begin
        if (!rst_n) begin
            fval_r  <= 1'b0;
            fval_q  <= 1'b0;
            dval_r  <= 1'b0;
            data_r  <= '0;
            start_r <= 1'b0;
            start_q <= 1'b0;
        end else begin
            fval_r  <= iFVAL;
            fval_q  <= fval_r;
            dval_r  <= iDVAL;
            data_r  <= iDATA;
            start_r <= iCCD_start;
            start_q <= start_r;
        end
    end

    // Edge detection and capture qualifiers; pixels outside FVAL are dropped.
    always_comb begin
        fs          = fval_r & ~fval_q;
        fe          = ~fval_r & fval_q;
        start_pulse = start_r & ~start_q;
        cap_pix     = (state == CAPTURE) & dval_r & fval_r;
        last_pix    = cap_pix & (pix_cnt == LAST_PIX);
        issue       = cap_pix & (lane_full | last_pix);
        trunc       = (state == CAPTURE) & fe & iCCD_enable;
        lane_clr    = wren_r | (state == IDLE) | (state == ARM);
    end

    pixel_lane_packer #(
        .PIX_W        (PIX_W),
        .PIX_PER_WORD (PIX_PER_WORD)
    ) u_packer (
        .clk   (pxlclk),
        .rst_n (rst_n),
        .wr_en (cap_pix),
        .data  (data_r),
        .clr   (lane_clr),
        .word  (lane_word),
        .full  (lane_full)
    );

    // State register.
    always_ff @(posedge pxlclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; a low enable overrides everything.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_pulse) state_nx = ARM;
            ARM:     if (fs) state_nx = CAPTURE;
            CAPTURE: begin
                if (last_pix) state_nx = FLUSH;
                else if (fe)  state_nx = IDLE;
            end
            FLUSH:   state_nx = iCont ? ARM : IDLE;
            default: state_nx = IDLE;
        endcase
        if (!iCCD_enable) state_nx = IDLE;
    end

    // Pixel and word counters, held at zero outside CAPTURE.
    always_ff @(posedge pxlclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            word_cnt <= '0;
        end else if (state != CAPTURE) begin
            pix_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            if (cap_pix) pix_cnt  <= pix_cnt + PC_W'(1);
            if (issue)   word_cnt <= word_cnt + ADDR_W'(1);
        end
    end

    // Write strobe/address, done pulse and sticky truncation flag.
    always_ff @(posedge pxlclk or negedge rst_n) begin
        if (!rst_n) begin
            wren_r <= 1'b0;
            addr_r <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            wren_r <= issue & iCCD_enable;
            addr_r <= (issue & iCCD_enable) ? word_cnt : '0;
            done_r <= (state == FLUSH) & iCCD_enable;
            if ((state == IDLE) && start_pulse && iCCD_enable) err_r <= 1'b0;
            else if (trunc)                                    err_r <= 1'b1;
        end
    end

    assign oDmem_wren = wren_r;
    assign oDmem_addr = addr_r;
    assign oDmem_data = wren_r ? lane_word : '0;
    assign oState     = state;
    assign oBusy      = (state != IDLE);
    assign oCCD_done  = done_r;
    assign oFrame_err = err_r;

endmodule

// File: tb/tb_img_capture_packer.sv
// Bench for img_capture_packer: a default 784-pixel instance and a
// 20-pixel instance (padded last word), driven by randomized frames.
module tb_img_capture_packer;

    localparam int IMG1 = 784;
    localparam int IMG2 = 20;
    localparam int PPW  = 16;

    typedef struct {
        int           cyc;
        int           addr;
        logic [255:0] data;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b1;
    logic         start = 1'b0;
    logic         start2 = 1'b0;
    logic         cont = 1'b0;
    logic         cont2 = 1'b0;
    logic         fval = 1'b0;
    logic         dval = 1'b0;
    logic [15:0]  data = '0;

    logic         wren1, busy1, done1, err1;
    logic [6:0]   addr1;
    logic [255:0] data1;
    logic [1:0]   state1;
    logic         wren2, busy2, done2, err2;
    logic [6:0]   addr2;
    logic [255:0] data2;
    logic [1:0]   state2;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   due1 = -1;
    int   due2 = -1;
    int   done_seen1 = 0;
    int   done_seen2 = 0;
    int   done_exp1 = 0;
    int   done_exp2 = 0;
    wr_t  exp_q1[$];
    wr_t  exp_q2[$];
    logic [15:0] frame_pix [0:IMG1-1];

    img_capture_packer dut1 (
        .pxlclk (clk), .rst_n (rst_n), .iCCD_enable (enable), .iCCD_start (start),
        .iCont (cont), .iFVAL (fval), .iDVAL (dval), .iDATA (data),
        .oDmem_wren (wren1), .oDmem_addr (addr1), .oDmem_data (data1),
        .oState (state1), .oBusy (busy1), .oCCD_done (done1), .oFrame_err (err1)
    );

    img_capture_packer #(.PIX_W(16), .PIX_PER_WORD(16), .IMG_PIXELS(IMG2), .ADDR_W(7)) dut2 (
        .pxlclk (clk), .rst_n (rst_n), .iCCD_enable (enable), .iCCD_start (start2),
        .iCont (cont2), .iFVAL (fval), .iDVAL (dval), .iDATA (data),
        .oDmem_wren (wren2), .oDmem_addr (addr2), .oDmem_data (data2),
        .oState (state2), .oBusy (busy2), .oCCD_done (done2), .oFrame_err (err2)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected word w: pixels w*16 .. w*16+15 of the frame, zero beyond limit.
    function automatic logic [255:0] word_of(input int w, input int limit);
        logic [255:0] d;
        d = '0;
        for (int k = 0; k < PPW; k++) begin
            if (w * PPW + k < limit) d[k*16 +: 16] = frame_pix[w * PPW + k];
        end
        return d;
    endfunction

    task automatic monitor();
        wr_t w;
        logic e1, e2;
        if (exp_q1.size() > 0 && exp_q1[0].cyc == cyc) begin
            w = exp_q1.pop_front();
            check("wr1_en", 256'(wren1), 256'(1));
            check("wr1_addr", 256'(addr1), 256'(w.addr));
            check("wr1_data", data1, w.data);
        end else if (wren1) begin
            check("wr1_spurious", 256'(wren1), 256'(0));
        end
        if (exp_q2.size() > 0 && exp_q2[0].cyc == cyc) begin
            w = exp_q2.pop_front();
            check("wr2_en", 256'(wren2), 256'(1));
            check("wr2_addr", 256'(addr2), 256'(w.addr));
            check("wr2_data", data2, w.data);
        end else if (wren2) begin
            check("wr2_spurious", 256'(wren2), 256'(0));
        end
        e1 = (cyc == due1);
        e2 = (cyc == due2);
        if (done1 || e1) check("done1", 256'(done1), 256'(e1));
        if (done2 || e2) check("done2", 256'(done2), 256'(e2));
        if (done1) done_seen1++;
        if (done2) done_seen2++;
    endtask

    task automatic step(input logic f, input logic d, input logic [15:0] x);
        fval = f;
        dval = d;
        data = x;
        @(posedge clk);
        cyc++;
        #1;
        monitor();
    endtask

    task automatic check_idle1(input string tag);
        check({tag, "_wren"}, 256'(wren1), 256'(0));
        check({tag, "_addr"}, 256'(addr1), 256'(0));
        check({tag, "_data"}, data1, 256'(0));
        check({tag, "_state"}, 256'(state1), 256'(0));
        check({tag, "_busy"}, 256'(busy1), 256'(0));
        check({tag, "_done"}, 256'(done1), 256'(0));
        check({tag, "_err"}, 256'(err1), 256'(0));
    endtask

    task automatic pulse_start(input logic s1, input logic s2);
        start  = s1;
        start2 = s2;
        step(0, 0, 16'h0);
        start  = 1'b0;
        start2 = 1'b0;
        repeat (3) step(0, 0, 16'h0);
    endtask

    // One frame of n_pix pixels. cap1/cap2 say whether each instance is
    // expected to capture it; *_at indices trigger mid-frame events (-1 = none).
    task automatic run_frame(input int n_pix, input int fnum, input bit rnd,
                             input bit cap1, input bit cap2, input int start_at,
                             input int drop_at, input int rst_at, input int cont_clr_at);
        logic [15:0] v;
        bit live1, live2;
        repeat (4) step(0, 0, 16'h0);
        repeat (2) step(1, 0, 16'h0);
        for (int p = 0; p < n_pix; p++) begin
            v = rnd ? 16'($urandom) : 16'(fnum * 1000 + p);
            frame_pix[p] = v;
            if (p == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_idle1("async_rst");
                repeat (2) step(1, 0, 16'h0);
                rst_n = 1'b1;
            end
            if (p == start_at)    start  = 1'b1;
            if (p == drop_at)     enable = 1'b0;
            if (p == cont_clr_at) cont   = 1'b0;
            if ($urandom_range(0, 4) == 0) step(1, 0, 16'hdead);
            step(1, 1, v);
            start = 1'b0;
            live1 = cap1 && (drop_at < 0 || p < drop_at) && (rst_at < 0 || p < rst_at) && p < IMG1;
            live2 = cap2 && (drop_at < 0 || p < drop_at) && (rst_at < 0 || p < rst_at) && p < IMG2;
            if (live1 && (p % PPW == PPW - 1 || p == IMG1 - 1))
                exp_q1.push_back('{cyc + 1, p / PPW, word_of(p / PPW, IMG1)});
            if (live1 && p == IMG1 - 1) begin
                due1 = cyc + 2;
                done_exp1++;
            end
            if (live2 && (p % PPW == PPW - 1 || p == IMG2 - 1))
                exp_q2.push_back('{cyc + 1, p / PPW, word_of(p / PPW, IMG2)});
            if (live2 && p == IMG2 - 1) begin
                due2 = cyc + 2;
                done_exp2++;
            end
            if (p == drop_at) check_idle1("en_drop");
        end
        repeat (2) step(1, 0, 16'h0);
        repeat (6) step(0, 0, 16'h0);
    endtask

    initial begin
        // Reset.
        repeat (3) step(0, 0, 16'h0);
        check_idle1("reset");
        check("reset_state2", 256'(state2), 256'(0));
        rst_n = 1'b1;
        repeat (2) step(0, 0, 16'h0);

        // Clean frame on both instances; small one pads its last word.
        pulse_start(1, 1);
        check("armed_state", 256'(state1), 256'(1));
        check("armed_busy", 256'(busy1), 256'(1));
        run_frame(IMG1, 0, 1, 1, 1, -1, -1, -1, -1);
        check("f1_state", 256'(state1), 256'(0));
        check("f1_done_cnt", 256'(done_seen1), 256'(done_exp1));
        check("f1_done_cnt2", 256'(done_seen2), 256'(done_exp2));

        // Start in the middle of a frame: that frame is skipped.
        run_frame(IMG1, 0, 1, 0, 0, 200, -1, -1, -1);
        check("mid_state", 256'(state1), 256'(1));
        run_frame(IMG1, 0, 1, 1, 0, -1, -1, -1, -1);
        check("mid_done_cnt", 256'(done_seen1), 256'(done_exp1));

        // Truncated frame after 500 pixels.
        pulse_start(1, 0);
        run_frame(500, 0, 1, 1, 0, -1, -1, -1, -1);
        check("trunc_err", 256'(err1), 256'(1));
        check("trunc_state", 256'(state1), 256'(0));
        check("trunc_done_cnt", 256'(done_seen1), 256'(done_exp1));
        pulse_start(1, 0);
        check("restart_err", 256'(err1), 256'(0));
        run_frame(IMG1, 0, 1, 1, 0, -1, -1, -1, -1);

        // Continuous mode, three frames; cont dropped during the third.
        cont = 1'b1;
        pulse_start(1, 0);
        run_frame(IMG1, 0, 0, 1, 0, -1, -1, -1, -1);
        check("cont_f0_state", 256'(state1), 256'(1));
        run_frame(IMG1, 1, 0, 1, 0, -1, -1, -1, -1);
        check("cont_f1_state", 256'(state1), 256'(1));
        run_frame(IMG1, 2, 0, 1, 0, -1, -1, -1, 500);
        check("cont_f2_state", 256'(state1), 256'(0));
        check("cont_done_cnt", 256'(done_seen1), 256'(done_exp1));

        // Enable dropped at pixel 100.
        pulse_start(1, 0);
        run_frame(IMG1, 0, 1, 1, 0, -1, 100, -1, -1);
        enable = 1'b1;
        check_idle1("after_drop");

        // Asynchronous reset at pixel 300.
        pulse_start(1, 0);
        run_frame(IMG1, 0, 1, 1, 0, -1, -1, 300, -1);
        check_idle1("after_rst");

        check("pending_q1", 256'(exp_q1.size()), 256'(0));
        check("pending_q2", 256'(exp_q2.size()), 256'(0));
        check("total_done1", 256'(done_seen1), 256'(done_exp1));
        check("total_done2", 256'(done_seen2), 256'(done_exp2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
